// File: rtl/poc_usbdev_pkg.sv
// Shared encodings for the poc_usbdev full-speed USB receiver: line states,
// PID constants, CRC polynomials/residuals and the packet FSM state type.
package poc_usbdev_pkg;

  // Line state is {D+, D-}; SE1 is folded into SE0 by the PHY.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_e;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_ERR  = 3'd4
  } rx_state_e;

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_phy.sv
// Receive PHY: synchronizes D+/D-, recovers the bit clock from line edges,
// NRZI-decodes J/K samples and strips stuffed bits while rx_en is high.
module usb_rx_phy
  import poc_usbdev_pkg::*;
#(
  parameter int OSR = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx_en,
  input  logic  dp,
  input  logic  dm,
  output logic  smp_valid,
  output line_e smp_line,
  output logic  bit_valid,
  output logic  rx_bit,
  output logic  se0,
  output logic  stuff_err
);

  localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] SMP_PHASE = PW'(OSR / 2);

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  line_e         line_cur;
  line_e         line_q;
  line_e         prev_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase;
  logic [2:0]    ones_q;
  logic          se0_q;
  logic          jk_smp;
  logic          same;

  always_comb begin
    case (sync2_q)
      2'b10:   line_cur = LINE_J;
      2'b01:   line_cur = LINE_K;
      default: line_cur = LINE_SE0;
    endcase
  end

  // An edge restarts the phase in the same clk, so samples land 2 clk after it.
  assign phase     = (line_cur != line_q) ? '0 : phase_q;
  assign smp_valid = (phase == SMP_PHASE);
  assign smp_line  = line_cur;
  assign jk_smp    = smp_valid && (line_cur != LINE_SE0);
  assign same      = (line_cur == prev_q);

  // bit_valid is a one-clk strobe qualifying rx_bit; stuffed bits never raise it.
  assign rx_bit    = same;
  assign bit_valid = jk_smp && !(rx_en && (ones_q == 3'd6));
  assign stuff_err = jk_smp && rx_en && (ones_q == 3'd6) && same;
  assign se0       = se0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      line_q  <= LINE_SE0;
      phase_q <= '0;
      prev_q  <= LINE_J;
      ones_q  <= '0;
      se0_q   <= 1'b0;
    end else begin
      sync1_q <= {dp, dm};
      sync2_q <= sync1_q;
      line_q  <= line_cur;
      phase_q <= phase + 1'b1;
      se0_q   <= (line_cur == LINE_SE0);
      if (jk_smp) begin
        prev_q <= line_cur;
      end else if (smp_valid) begin
        prev_q <= LINE_J;
      end
      if (!rx_en || (smp_valid && !jk_smp)) begin
        ones_q <= '0;
      end else if (jk_smp) begin
        ones_q <= ((ones_q == 3'd6) || !same) ? 3'd0 : ones_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/poc_usbdev.sv
// TinyTapeout tile top: full-speed USB receive-only front end with SYNC/EOP
// detection, byte assembly, PID and CRC5/CRC16 checking.
module poc_usbdev
  import poc_usbdev_pkg::*;
#(
  parameter int OSR            = 4,
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] MIN_ZEROS = 4'(SYNC_MIN_ZEROS);

  logic      rst;
  logic      rx_en;
  logic      smp_valid;
  line_e     smp_line;
  logic      bit_valid;
  logic      rx_bit;
  logic      se0;
  logic      phy_stuff_err;
  logic      unused_ok;

  rx_state_e   state_q;
  logic [3:0]  zero_cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  pid_q;
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic        pid_err_q;
  logic        stuff_err_q;
  logic        crc_err_q;
  logic [7:0]  uo_q;
  logic        byte_stb_q;
  logic        eop_stb_q;
  logic        pkt_ok_q;
  logic        rx_active_q;
  logic        err_se0_q;

  logic [7:0]  new_byte;
  logic        crc_bad;
  logic        align_bad;
  logic        no_pid;
  logic        smp_j;
  logic        smp_k;
  logic        smp_se0;

  assign rst       = rst_n;
  assign unused_ok = ^{ena, uio_in, ui_in[7:2]};
  assign rx_en     = (state_q == ST_HUNT) || (state_q == ST_DATA);

  usb_rx_phy #(.OSR(OSR)) u_phy (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .dp        (ui_in[0]),
    .dm        (ui_in[1]),
    .smp_valid (smp_valid),
    .smp_line  (smp_line),
    .bit_valid (bit_valid),
    .rx_bit    (rx_bit),
    .se0       (se0),
    .stuff_err (phy_stuff_err)
  );

  assign smp_j    = smp_valid && (smp_line == LINE_J);
  assign smp_k    = smp_valid && (smp_line == LINE_K);
  assign smp_se0  = smp_valid && (smp_line == LINE_SE0);
  assign new_byte = {rx_bit, shift_q[7:1]};

  // End-of-packet checks selected by the PID type in its low two bits.
  always_comb begin
    crc_bad   = 1'b0;
    align_bad = (bit_cnt_q != 3'd0);
    no_pid    = (byte_cnt_q == 2'd0);
    case (pid_q[1:0])
      2'b01:   crc_bad = (crc5_q != CRC5_RESIDUAL);
      2'b11:   crc_bad = (crc16_q != CRC16_RESIDUAL);
      2'b10:   crc_bad = (byte_cnt_q != 2'd1);
      default: crc_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      zero_cnt_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      pid_q       <= '0;
      crc5_q      <= '0;
      crc16_q     <= '0;
      pid_err_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      crc_err_q   <= 1'b0;
      uo_q        <= '0;
      byte_stb_q  <= 1'b0;
      eop_stb_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      rx_active_q <= 1'b0;
      err_se0_q   <= 1'b0;
    end else begin
      byte_stb_q <= 1'b0;
      eop_stb_q  <= 1'b0;
      pkt_ok_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (smp_k) begin
            state_q    <= ST_HUNT;
            zero_cnt_q <= '0;
          end
        end
        ST_HUNT: begin
          if (smp_se0) begin
            state_q <= ST_IDLE;
          end else if (bit_valid) begin
            if (!rx_bit) begin
              if (zero_cnt_q != 4'hF) zero_cnt_q <= zero_cnt_q + 4'd1;
            end else if (zero_cnt_q >= MIN_ZEROS) begin
              state_q     <= ST_DATA;
              rx_active_q <= 1'b1;
              pid_err_q   <= 1'b0;
              stuff_err_q <= 1'b0;
              crc_err_q   <= 1'b0;
              bit_cnt_q   <= '0;
              byte_cnt_q  <= '0;
              pid_q       <= '0;
              crc5_q      <= CRC5_INIT;
              crc16_q     <= CRC16_INIT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (phy_stuff_err) begin
            state_q     <= ST_ERR;
            stuff_err_q <= 1'b1;
            rx_active_q <= 1'b0;
            err_se0_q   <= 1'b0;
          end else if (smp_se0) begin
            state_q <= ST_EOP;
          end else if (bit_valid) begin
            shift_q   <= new_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_cnt_q != 2'd0) begin
              crc5_q  <= crc5_step(crc5_q, rx_bit);
              crc16_q <= crc16_step(crc16_q, rx_bit);
            end
            if (bit_cnt_q == 3'd7) begin
              uo_q       <= new_byte;
              byte_stb_q <= 1'b1;
              if (byte_cnt_q == 2'd0) begin
                pid_q <= new_byte;
                if (new_byte[7:4] != ~new_byte[3:0]) pid_err_q <= 1'b1;
              end
              if (byte_cnt_q != 2'd3) byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        ST_EOP: begin
          if (smp_j) begin
            state_q     <= ST_IDLE;
            rx_active_q <= 1'b0;
            eop_stb_q   <= 1'b1;
            if (align_bad) stuff_err_q <= 1'b1;
            if (no_pid)    pid_err_q   <= 1'b1;
            if (crc_bad)   crc_err_q   <= 1'b1;
            pkt_ok_q <= !(pid_err_q || stuff_err_q || crc_err_q ||
                          align_bad || no_pid || crc_bad);
          end else if (smp_k) begin
            state_q     <= ST_ERR;
            stuff_err_q <= 1'b1;
            rx_active_q <= 1'b0;
            err_se0_q   <= 1'b0;
          end
        end
        ST_ERR: begin
          if (smp_se0) begin
            err_se0_q <= 1'b1;
          end else if (smp_j && err_se0_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {se0, pkt_ok_q, crc_err_q, stuff_err_q, pid_err_q,
                    eop_stb_q, rx_active_q, byte_stb_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_poc_usbdev.sv
// Directed bench for poc_usbdev: NRZI/bit-stuffing line driver, strobe
// monitor, expected-byte queue and per-packet status checks.
module tb_poc_usbdev;

  localparam int OSR = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  poc_usbdev dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: counts strobes and records every received byte.
  logic [7:0] got_q[$];
  int n_byte = 0, n_eop = 0, n_ok = 0, n_ok_eop = 0, n_act = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (uio_out[0]) begin
        n_byte++;
        got_q.push_back(uo_out);
      end
      if (uio_out[2]) n_eop++;
      if (uio_out[6]) n_ok++;
      if (uio_out[2] && uio_out[6]) n_ok_eop++;
      if (uio_out[1]) n_act++;
    end
  end

  // Line driver state.
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  bit         tx_j;
  bit         stuff_on;
  bit         jit_on;
  int         jit_idx;
  int         ones;
  int         rd = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit dp, input bit dm);
    ui_in = {6'b000000, dm, dp};
  endtask

  task automatic get_jit(output int j);
    if (jit_on) begin
      case (jit_idx % 4)
        0:       j = 0;
        1:       j = 1;
        2:       j = 2;
        default: j = 1;
      endcase
      jit_idx++;
    end else begin
      j = 0;
    end
  endtask

  task automatic send_raw(input bit b);
    int j;
    if (!b) begin
      get_jit(j);
      wait_clk(j);
      tx_j = !tx_j;
      if (tx_j) drive(1'b1, 1'b0);
      else      drive(1'b0, 1'b1);
      wait_clk(OSR - j);
    end else begin
      wait_clk(OSR);
    end
  endtask

  task automatic send_bit(input bit b);
    send_raw(b);
    if (b) ones++;
    else   ones = 0;
    if (stuff_on && ones == 6) begin
      send_raw(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_packet();
    int j;
    logic [7:0] v;
    ones = 0;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < tx_q.size(); k++) begin
      v = tx_q[k];
      for (int i = 0; i < 8; i++) send_bit(v[i]);
    end
    get_jit(j);
    wait_clk(j);
    drive(1'b0, 1'b0);
    wait_clk(2 * OSR);
    drive(1'b1, 1'b0);
    tx_j = 1'b1;
    wait_clk(24);
  endtask

  // Transmit-side CRC16 over tx_q[1..]: inverted remainder, sent MSB first.
  task automatic append_crc16();
    logic [15:0] c;
    logic [7:0]  lo, hi, v;
    bit fb;
    c = 16'hFFFF;
    for (int k = 1; k < tx_q.size(); k++) begin
      v = tx_q[k];
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ v[i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    c = ~c;
    for (int i = 0; i < 8; i++) begin
      lo[i] = c[15 - i];
      hi[i] = c[7 - i];
    end
    tx_q.push_back(lo);
    tx_q.push_back(hi);
  endtask

  task automatic run_pkt(input string tag, input int exp_eop, input int exp_ok,
                         input bit exp_pid, input bit exp_stuff, input bit exp_crc);
    int b0, e0, o0, oe0, nexp;
    b0 = n_byte; e0 = n_eop; o0 = n_ok; oe0 = n_ok_eop;
    nexp = exp_q.size();
    send_packet();
    check_eq({tag, "_nbytes"}, n_byte - b0, nexp);
    while (exp_q.size() > 0) begin
      if (rd < got_q.size()) begin
        check_eq({tag, "_byte"}, got_q[rd], exp_q.pop_front());
        rd++;
      end else begin
        void'(exp_q.pop_front());
      end
    end
    rd = got_q.size();
    check_eq({tag, "_eop"}, n_eop - e0, exp_eop);
    check_eq({tag, "_ok"}, n_ok - o0, exp_ok);
    check_eq({tag, "_ok_with_eop"}, n_ok_eop - oe0, exp_ok);
    check_eq({tag, "_pid_err"}, uio_out[3], exp_pid);
    check_eq({tag, "_stuff_err"}, uio_out[4], exp_stuff);
    check_eq({tag, "_crc_err"}, uio_out[5], exp_crc);
    check_eq({tag, "_rx_active"}, uio_out[1], 1'b0);
  endtask

  initial begin
    int b0, e0, o0, a0;
    ena = 1'b1;
    uio_in = 8'h00;
    ui_in = 8'h00;
    tx_j = 1'b1;
    stuff_on = 1'b1;
    jit_on = 1'b0;
    jit_idx = 0;

    // Reset held 3 clk while the line toggles.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i[0], ~i[0]);
    end
    @(negedge clk);
    check_eq("reset_uo_out", uo_out, 8'h00);
    check_eq("reset_uio_out", uio_out, 8'h00);
    check_eq("reset_uio_oe", uio_oe, 8'hFF);

    drive(1'b1, 1'b0);
    rst_n = 1'b0;
    b0 = n_byte; e0 = n_eop; o0 = n_ok;
    wait_clk(100);
    check_eq("idle_byte_stb", n_byte - b0, 0);
    check_eq("idle_eop_stb", n_eop - e0, 0);
    check_eq("idle_pkt_ok", n_ok - o0, 0);

    tx_q = '{8'hD2};
    exp_q = tx_q;
    run_pkt("ack", 1, 1, 1'b0, 1'b0, 1'b0);

    tx_q = '{8'hE1, 8'h00, 8'h10};
    exp_q = tx_q;
    run_pkt("out_tok", 1, 1, 1'b0, 1'b0, 1'b0);

    tx_q = '{8'hE1, 8'h00, 8'h18};
    exp_q = tx_q;
    run_pkt("out_badcrc", 1, 0, 1'b0, 1'b0, 1'b1);

    tx_q = '{8'hC3, 8'h00, 8'h01};
    append_crc16();
    exp_q = tx_q;
    run_pkt("data0", 1, 1, 1'b0, 1'b0, 1'b0);

    tx_q = '{8'hC3, 8'hFF};
    append_crc16();
    exp_q = tx_q;
    run_pkt("data0_ff", 1, 1, 1'b0, 1'b0, 1'b0);

    // Seven ones without the stuffed zero: only the PID byte completes.
    stuff_on = 1'b0;
    tx_q = '{8'hC3, 8'hFF};
    exp_q = '{8'hC3};
    a0 = n_act;
    run_pkt("stuff", 0, 0, 1'b0, 1'b1, 1'b0);
    check_eq("stuff_rx_active_seen", (n_act - a0) > 0, 1'b1);
    stuff_on = 1'b1;

    tx_q = '{8'hD2};
    exp_q = tx_q;
    run_pkt("ack_after_stuff", 1, 1, 1'b0, 1'b0, 1'b0);

    // Data-type PID with no CRC field also leaves the CRC16 residual wrong.
    tx_q = '{8'hD3};
    exp_q = tx_q;
    run_pkt("bad_pid", 1, 0, 1'b1, 1'b0, 1'b1);

    jit_on = 1'b1;
    jit_idx = 0;
    tx_q = '{8'hD2};
    exp_q = tx_q;
    run_pkt("ack_jitter", 1, 1, 1'b0, 1'b0, 1'b0);
    jit_on = 1'b0;

    check_eq("final_uio_oe", uio_oe, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
